// File: rtl/timer_alarm.sv
// Programmable alarm stage fed by a 15-bit wrapping timer: one-shot or periodic
// deadlines, sticky pending flag and a saturating count of alarms missed while pending.
//
// state | meaning
// IDLE  | disarmed, accepting arm requests
// ARMED | deadline loaded, comparing timer_q against it every valid cycle
module timer_alarm #(
   parameter int MAX_DELAY = 16383,
   parameter int MISS_W    = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clock_valid,
   input  logic [15:0]       timer_in,
   input  logic              set_valid,
   output logic              set_ready,
   input  logic [14:0]       set_delay,
   input  logic              set_periodic,
   input  logic              cancel,
   input  logic              ack,
   output logic              armed,
   output logic              alarm_pending,
   output logic [MISS_W-1:0] missed_count
);

   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

   localparam logic [14:0]       MAX_D    = 15'(MAX_DELAY);
   localparam logic [MISS_W-1:0] MISS_MAX = '1;
   localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

   state_t      state, state_nxt;
   logic [14:0] timer_q, deadline, period, diff, delay_c;
   logic        mode, reached, fire, accept;
   logic        unused_timer_msb;

   assign unused_timer_msb = timer_in[15];

   always_comb begin
      delay_c = set_delay;
      if (set_delay == 15'd0)
         delay_c = 15'd1;
      else if (set_delay > MAX_D)
         delay_c = MAX_D;
   end

   // Deadlines are at most half the wrap range ahead, so the sign bit of the
   // modular difference tells "reached" from "still ahead".
   assign diff    = timer_q - deadline;
   assign reached = ~diff[14];
   assign accept  = set_valid & set_ready;
   assign fire    = clock_valid & (state == ARMED) & reached & ~cancel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else if (clock_valid)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ARMED;
         ARMED:   if (cancel || (fire && !mode)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      armed     = (state == ARMED);
      set_ready = clock_valid & (state == IDLE) & ~cancel;
   end

   // Periodic reload advances from the old deadline so the period never drifts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q  <= '0;
         deadline <= '0;
         period   <= '0;
         mode     <= 1'b0;
      end else if (clock_valid) begin
         timer_q <= timer_in[14:0];
         if (accept) begin
            deadline <= timer_q + delay_c;
            period   <= delay_c;
            mode     <= set_periodic;
         end else if (fire && mode) begin
            deadline <= deadline + period;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alarm_pending <= 1'b0;
         missed_count  <= '0;
      end else if (clock_valid) begin
         if (fire) begin
            alarm_pending <= 1'b1;
            if (ack)
               missed_count <= '0;
            else if (alarm_pending && missed_count != MISS_MAX)
               missed_count <= missed_count + MISS_ONE;
         end else if (ack) begin
            alarm_pending <= 1'b0;
            missed_count  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: stimulus queues expected output snapshots,
// a monitor pops and compares them on the falling clock edge.
module tb_timer_alarm;

   logic        clock = 1'b0;
   logic        reset;
   logic        clock_valid;
   logic [15:0] timer_in;
   logic        set_valid;
   logic        set_ready;
   logic [14:0] set_delay;
   logic        set_periodic;
   logic        cancel;
   logic        ack;
   logic        armed;
   logic        alarm_pending;
   logic [7:0]  missed_count;

   typedef struct {
      string      name;
      logic       armed;
      logic       pend;
      logic [7:0] miss;
      logic       rdy;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   timer_alarm #(.MAX_DELAY(16383), .MISS_W(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .clock_valid   (clock_valid),
      .timer_in      (timer_in),
      .set_valid     (set_valid),
      .set_ready     (set_ready),
      .set_delay     (set_delay),
      .set_periodic  (set_periodic),
      .cancel        (cancel),
      .ack           (ack),
      .armed         (armed),
      .alarm_pending (alarm_pending),
      .missed_count  (missed_count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (armed !== e.armed || alarm_pending !== e.pend ||
                missed_count !== e.miss || set_ready !== e.rdy) begin
               tests_failed++;
               $display("FAIL %s: got armed=%b pend=%b miss=%0d rdy=%b, expected armed=%b pend=%b miss=%0d rdy=%b",
                        e.name, armed, alarm_pending, missed_count, set_ready,
                        e.armed, e.pend, e.miss, e.rdy);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic a, input logic p,
                      input logic [7:0] m, input logic r);
      exp_t e;
      e.name = name; e.armed = a; e.pend = p; e.miss = m; e.rdy = r;
      exp_q.push_back(e);
   endtask

   task automatic set_timer(input logic [15:0] v);
      timer_in = v;
      tick(1);
   endtask

   task automatic arm(input logic [14:0] d, input logic per);
      set_valid    = 1'b1;
      set_delay    = d;
      set_periodic = per;
      tick(1);
      set_valid    = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clock_valid = 1'b1; timer_in = '0; set_valid = 1'b0;
      set_delay = '0; set_periodic = 1'b0; cancel = 1'b0; ack = 1'b0;
      tick(2);
      chk("reset_state", 0, 0, 0, 1);
      reset = 1'b0;

      // one-shot, bit 15 of the timer set to show it is ignored
      set_timer(16'h8064);
      arm(15'd10, 1'b0);
      chk("os_armed", 1, 0, 0, 0);
      timer_in = 16'd110;
      tick(1);
      chk("os_latency", 1, 0, 0, 0);
      tick(1);
      chk("os_fire", 0, 1, 0, 1);
      tick(3);
      chk("os_single_fire", 0, 1, 0, 1);
      do_ack();
      chk("os_ack", 0, 0, 0, 1);

      // wrap: 32760 + 20 -> 12
      set_timer(16'd32760);
      arm(15'd20, 1'b0);
      set_timer(16'd32767); tick(1);
      chk("wrap_32767", 1, 0, 0, 0);
      set_timer(16'd0); tick(1);
      chk("wrap_0", 1, 0, 0, 0);
      set_timer(16'd11); tick(1);
      chk("wrap_11", 1, 0, 0, 0);
      set_timer(16'd12);
      chk("wrap_12_latency", 1, 0, 0, 0);
      tick(1);
      chk("wrap_12_fire", 0, 1, 0, 1);
      do_ack();

      // periodic, period 5
      set_timer(16'd0);
      arm(15'd5, 1'b1);
      set_timer(16'd5); tick(1);
      chk("per_5", 1, 1, 0, 0);
      tick(2);
      chk("per_5_once", 1, 1, 0, 0);
      set_timer(16'd10); tick(1);
      chk("per_10", 1, 1, 1, 0);
      set_timer(16'd15); tick(1);
      chk("per_15", 1, 1, 2, 0);
      set_timer(16'd20);
      do_ack();
      chk("per_20_ack_fire", 1, 1, 0, 0);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      chk("per_cancel_keeps_pend", 0, 1, 0, 1);
      do_ack();
      chk("per_ack_clear", 0, 0, 0, 1);

      // delay 0 coerced to 1
      set_timer(16'd200);
      arm(15'd0, 1'b0);
      tick(2);
      chk("zero_delay_early", 1, 0, 0, 0);
      set_timer(16'd201); tick(1);
      chk("zero_delay_fire", 0, 1, 0, 1);
      do_ack();

      // delay 20000 clamped to 16383: deadline 1000+16383 = 17383
      set_timer(16'd1000);
      arm(15'd20000, 1'b0);
      set_timer(16'd17382); tick(1);
      chk("clamp_before", 1, 0, 0, 0);
      set_timer(16'd17383); tick(1);
      chk("clamp_fire", 0, 1, 0, 1);
      do_ack();

      // saturation: deadline far behind timer_q, fires every cycle
      set_timer(16'd0);
      arm(15'd1, 1'b1);
      set_timer(16'd8000);
      tick(10);
      chk("sat_10_fires", 1, 1, 9, 0);
      tick(290);
      chk("sat_300_fires", 1, 1, 255, 0);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      chk("sat_after_cancel", 0, 1, 255, 1);
      do_ack();
      chk("sat_ack", 0, 0, 0, 1);

      // cancel racing a reached deadline
      set_timer(16'd0);
      arm(15'd5, 1'b0);
      set_timer(16'd5);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      chk("cancel_race", 0, 0, 0, 1);
      tick(2);
      chk("cancel_race_idle", 0, 0, 0, 1);

      // cancel with set_valid in IDLE
      settle();
      cancel = 1'b1; set_valid = 1'b1; set_delay = 15'd3; set_periodic = 1'b0;
      chk("cancel_set_ready", 0, 0, 0, 0);
      tick(1);
      chk("cancel_set_stays_idle", 0, 0, 0, 0);
      settle();
      cancel = 1'b0; set_valid = 1'b0;

      // stall across the deadline
      set_timer(16'd0);
      arm(15'd3, 1'b0);
      clock_valid = 1'b0;
      timer_in = 16'd3;
      tick(4);
      chk("stall_hold", 1, 0, 0, 0);
      settle();
      clock_valid = 1'b1;
      tick(1);
      chk("stall_resume_load", 1, 0, 0, 0);
      tick(1);
      chk("stall_resume_fire", 0, 1, 0, 1);
      do_ack();

      // async reset while armed and pending
      set_timer(16'd0);
      arm(15'd2, 1'b1);
      set_timer(16'd2); tick(1);
      set_timer(16'd4); tick(1);
      chk("pre_reset", 1, 1, 1, 0);
      settle();
      reset = 1'b1;
      #1;
      chk("async_reset", 0, 0, 0, 1);
      tick(1);
      reset = 1'b0;
      tick(1);
      chk("after_reset", 0, 0, 0, 1);

      settle();
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/timer_alarm.md
# timer_alarm

Programmable alarm stage directly downstream of the 781250 Hz free-running timer. It consumes the 16-bit timer value, of which bits 14:0 wrap from 32767 to 0. A client arms it with a delay in timer ticks, in one-shot or periodic mode. The block raises a sticky `alarm_pending` flag when the deadline is reached, counts alarms missed while the flag is still pending, and clears on acknowledge.

## Interface
- `MAX_DELAY`, default 16383: largest accepted delay in ticks. Must be ≤ 16383 (half the 15-bit wrap range).
- `MISS_W`, default 8: width of the missed-alarm counter.

Ports:
- `clock`  in  1: system clock. Only clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `clock_valid`  in  1: when 0, every register holds its value and no handshake is accepted.
- `timer_in`  in  16: timer value. Bit 15 is ignored.
- `set_valid`  in  1: arm request.
- `set_ready`  out  1: equals `clock_valid & (state==IDLE) & ~cancel`.
- `set_delay`  in  15: ticks until the first alarm. Also used as the reload period in periodic mode.
- `set_periodic`  in  1: 1 selects periodic mode, 0 selects one-shot.
- `cancel`  in  1: disarm.
- `ack`  in  1: acknowledge a pending alarm.
- `armed`  out  1: state==ARMED.
- `alarm_pending`  out  1: sticky alarm flag.
- `missed_count`  out  MISS_W: number of fires that occurred while `alarm_pending` was already 1. Saturating.

## Operation
- **Input register:** `timer_q <= timer_in[14:0]` every valid cycle. All comparisons use `timer_q`.
- **Delay coercion:** a delay of 0 is treated as 1. A delay above `MAX_DELAY` is clamped to `MAX_DELAY`. The coerced value is stored in `period`.
- **States:** IDLE and ARMED.
  - IDLE → ARMED on `set_valid & set_ready`. On that transition: `deadline <= timer_q + delay` (mod 2^15), `period <= delay`, `mode <= set_periodic`.
  - ARMED → IDLE on `cancel`, or on a fire in one-shot mode.
  - In ARMED, `cancel` has priority over a fire in the same cycle: no fire occurs.
- **Reached test (wrap-aware):** `diff = timer_q - deadline` (15 bits, mod 2^15). Reached when `diff[14]==0`. Because delays are ≤ 16383, an armed deadline always reads as not-yet-reached at arm time.
- **Fire:** occurs when the state is ARMED and the deadline is reached. In periodic mode, `deadline <= deadline + period` (mod 2^15) and the state stays ARMED. The next deadline is computed from the old deadline, not from `timer_q`, so there is no drift.
- **Pending flag and miss counter:**
  - Fire with `alarm_pending==0`: set `alarm_pending`.
  - Fire with `alarm_pending==1` and no `ack`: `missed_count` increments, saturating at 2^MISS_W−1.
  - `ack` without a fire: clears `alarm_pending` and `missed_count`.
  - `ack` and fire in the same cycle: `alarm_pending` stays 1 and `missed_count` becomes 0.
- **Independence of cancel:** `cancel` does not clear `alarm_pending` or `missed_count`. Only `ack` clears them.
- **clock_valid low:** no state, register or counter changes. `set_ready` is 0.

## Timing
- **Reset values:** state IDLE, `timer_q`=0, `deadline`=0, `period`=0, `armed`=0, `alarm_pending`=0, `missed_count`=0. `set_ready` follows its equation and is therefore 1 once `cancel`=0 and `clock_valid`=1.
- **Reset assertion:** asynchronous; all outputs go to reset values immediately, including mid-operation. Deassertion is sampled by `clock`.
- **Arm latency:** `armed` rises at the edge that accepts the request.
- **Alarm latency:** `alarm_pending` rises at the second rising edge after `timer_in` first presents a reached value. One edge loads `timer_q`; the next registers the fire.
- **Pulse width:** one timer tick spans many clocks, but a fire is evaluated only in ARMED. In one-shot mode the state leaves ARMED on the fire edge, so exactly one fire occurs. In periodic mode the deadline advances on the fire edge, so one fire occurs per period.
- **Ack and cancel:** `ack` takes effect at the next edge. `cancel` drops `armed` at the next edge.

## Test plan
- **One-shot:** reset; `timer_in`=100; arm with delay 10, one-shot. `timer_in` steps to 110 → `alarm_pending`=1 two edges later, `armed`=0. `ack` → `alarm_pending`=0, `missed_count`=0.
- **Wrap:** `timer_in`=32760; arm with delay 20, so deadline = 12. Step `timer_in` 32767 → 0 → 11: no alarm. Step to 12: alarm fires.
- **Periodic without drift:** `timer_in`=0; arm with delay 5, periodic. Fires occur at 5, 10 and 15. Without `ack`, `missed_count`=2 after the 15 fire. Assert `ack` in the same cycle as the fire at 20 → `alarm_pending`=1, `missed_count`=0.
- **Coercion and saturation:** `set_delay`=0 fires one tick after arming. `set_delay`=20000 gives deadline = `timer_q`+16383. Force 300 fires without `ack` → `missed_count`=255.
- **Cancel races:** `cancel` in the same cycle as a reached deadline → no fire, `armed`=0. `cancel` together with `set_valid` in IDLE → `set_ready`=0, state stays IDLE.
- **Stall and reset:** hold `clock_valid`=0 across the deadline → nothing changes until it returns to 1, then the alarm fires. Assert `reset` asynchronously while ARMED with `alarm_pending`=1 → all outputs go to 0 before the next edge.
